// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state type, digit width and BCD radix helpers
package stopwatch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    localparam int DIGIT_W = 4;
    function automatic logic [3:0] radix_max(input logic mask_bit);
        return mask_bit ? 4'd5 : 4'd9;
    endfunction
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic mask_bit);
        return (d > radix_max(mask_bit)) ? radix_max(mask_bit) : d;
    endfunction
endpackage

// File: rtl/bcd_digit_cell.sv
// bcd_digit_cell: one up/down BCD digit with radix 10 or 6, clamped load
module bcd_digit_cell
    import stopwatch_pkg::*;
#(
    parameter bit IS_RADIX6 = 1'b0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                step,
    input  logic                dir,
    input  logic                ld,
    input  logic [DIGIT_W-1:0]  ld_val,
    output logic [DIGIT_W-1:0]  q,
    output logic                carry_out,
    output logic                is_zero
);
    localparam logic [DIGIT_W-1:0] MAX = radix_max(IS_RADIX6);
    assign is_zero   = q == '0;
    assign carry_out = dir ? is_zero : q == MAX;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            q <= '0;
        else if (ld)
            q <= clamp_digit(ld_val, IS_RADIX6);
        else if (step)
            q <= dir ? (is_zero ? MAX : q - 4'd1) : (carry_out ? '0 : q + 4'd1);
    end
endmodule

// File: rtl/stopwatch_lap_core.sv
// stopwatch_lap_core: BCD stopwatch/timer with lap freeze, preload and expiry
module stopwatch_lap_core
    import stopwatch_pkg::*;
#(
    parameter int                 NUM_DIG     = 6,
    parameter logic [NUM_DIG-1:0] RADIX6_MASK = 6'b101000
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         tick,
    input  logic                         start_stop,
    input  logic                         lap,
    input  logic                         clr,
    input  logic                         load,
    input  logic                         dir,
    input  logic [DIGIT_W*NUM_DIG-1:0]   load_val,
    output logic [DIGIT_W*NUM_DIG-1:0]   cnt,
    output logic [DIGIT_W*NUM_DIG-1:0]   disp,
    output logic                         running,
    output logic                         lap_hold,
    output logic                         expired
);
    localparam int W = DIGIT_W * NUM_DIG;
    state_t             state, nxt;
    logic [W-1:0]       snap;
    logic [NUM_DIG:0]   step;
    logic [NUM_DIG-1:0] carry, zero;
    logic               all_zero, ld, expire;
    assign all_zero = &zero;
    assign ld       = clr | (load & (state != RUN));
    // a down tick that lands on (or starts from) zero expires instead of wrapping
    assign expire   = !clr && state == RUN && tick && dir && (all_zero || cnt == W'(1));
    assign step[0]  = !clr && state == RUN && tick && !(dir && all_zero);
    assign disp     = lap_hold ? snap : cnt;
    genvar i;
    generate
        for (i = 0; i < NUM_DIG; i++) begin : g_dig
            assign step[i+1] = step[i] & carry[i];
            bcd_digit_cell #(.IS_RADIX6(RADIX6_MASK[i])) u_cell (
                .clk       (clk),
                .rstn      (rstn),
                .step      (step[i]),
                .dir       (dir),
                .ld        (ld),
                .ld_val    (clr ? 4'd0 : load_val[DIGIT_W*i +: DIGIT_W]),
                .q         (cnt[DIGIT_W*i +: DIGIT_W]),
                .carry_out (carry[i]),
                .is_zero   (zero[i])
            );
        end
    endgenerate
    always_comb begin
        nxt = clr ? IDLE :
              expire ? DONE :
              (load && state != RUN) ? (state == DONE ? IDLE : state) :
              start_stop ? (state == RUN ? PAUSE : state == DONE ? IDLE : RUN) :
              state;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            running  <= 1'b0;
            expired  <= 1'b0;
            lap_hold <= 1'b0;
            snap     <= '0;
        end else begin
            state   <= nxt;
            running <= nxt == RUN;
            expired <= nxt == DONE;
            if (clr) begin
                lap_hold <= 1'b0;
                snap     <= '0;
            end else if (lap && lap_hold) begin
                lap_hold <= 1'b0;
            end else if (lap && state == RUN) begin
                lap_hold <= 1'b1;
                snap     <= cnt;
            end
        end
    end
endmodule
